// File: rtl/cache_store_ctrl.sv
// Store front end for the 4-way data sets: tag lookup, pseudo-LRU replacement, eviction notice, one write pulse.
// Optional build macro CACHE_STORE_CTRL_STATS_EN adds stat_hits/stat_misses/stat_errs counters.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a store
// LOOKUP | tag compare, alignment check, way/victim choice
// EVICT  | evict_valid high until downstream takes the victim address
// WRITE  | single set_enable pulse, tag/valid/PLRU update
// RESP   | resp_valid high until the core accepts
module cache_store_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int NUM_SETS = 64,
  localparam int SET_BITS = $clog2(NUM_SETS),
  localparam int TAG_W    = ADDR_W - 6 - SET_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [63:0]         req_data,
  input  logic [1:0]          req_size,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic                resp_err,
  output logic                evict_valid,
  input  logic                evict_ready,
  output logic [ADDR_W-1:0]   evict_addr,
  output logic [SET_BITS-1:0] set_sel,
  output logic [1:0]          set_enable,
  output logic [3:0]          set_block_num,
  output logic [5:0]          set_block_offset,
  output logic [63:0]         set_write_data,
  output logic [1:0]          set_data_size
`ifdef CACHE_STORE_CTRL_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_errs
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_EVICT  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  init_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0][TAG_W-1:0] tag_mem [NUM_SETS];
  logic [3:0]            valid_q [NUM_SETS];
  logic [2:0]            plru_q  [NUM_SETS];

  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_W-1:0]      tag_in;
  logic [5:0]            offset;
  logic [3:0]            set_valid;
  logic [2:0]            set_plru;
  logic [3:0][TAG_W-1:0] set_tags;
  logic                  hit, inv_any, misaligned, accept;
  logic [1:0]            hit_way, inv_way, plru_way, way_sel;

  assign set_idx   = addr_q[6 +: SET_BITS];
  assign tag_in    = addr_q[ADDR_W-1 -: TAG_W];
  assign offset    = addr_q[5:0];
  assign set_valid = valid_q[set_idx];
  assign set_plru  = plru_q[set_idx];
  assign set_tags  = tag_mem[set_idx];

  // init_q keeps req_ready low while reset is asserted even though the state is IDLE
  assign req_ready   = (state_q == S_IDLE) && init_q;
  assign evict_valid = (state_q == S_EVICT);
  assign resp_valid  = (state_q == S_RESP);
  assign accept      = req_valid && req_ready;

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r = p;
    if (!w[1]) begin
      r[0] = 1'b1;
      r[1] = ~w[0];
    end else begin
      r[0] = 1'b0;
      r[2] = ~w[0];
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    inv_any = 1'b0;
    inv_way = 2'd0;
    // descending scan so the lowest matching index wins
    for (int i = 3; i >= 0; i--) begin
      if (set_valid[i] && (set_tags[i] == tag_in)) begin
        hit     = 1'b1;
        hit_way = 2'(i);
      end
      if (!set_valid[i]) begin
        inv_any = 1'b1;
        inv_way = 2'(i);
      end
    end
    plru_way = set_plru[0] ? {1'b1, set_plru[2]} : {1'b0, set_plru[1]};
    way_sel  = hit ? hit_way : (inv_any ? inv_way : plru_way);
    case (set_data_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = offset[0];
      2'd2:    misaligned = |offset[1:0];
      default: misaligned = |offset[2:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (misaligned)         state_d = S_RESP;
        else if (hit || inv_any) state_d = S_WRITE;
        else                     state_d = S_EVICT;
      end
      S_EVICT:  if (evict_ready) state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      init_q           <= 1'b0;
      addr_q           <= '0;
      resp_hit         <= 1'b0;
      resp_err         <= 1'b0;
      evict_addr       <= '0;
      set_sel          <= '0;
      set_enable       <= 2'b00;
      set_block_num    <= 4'd0;
      set_block_offset <= 6'd0;
      set_write_data   <= 64'd0;
      set_data_size    <= 2'd0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      set_enable <= (state_d == S_WRITE) ? 2'b01 : 2'b00;
      if (accept) begin
        addr_q           <= req_addr;
        set_sel          <= req_addr[6 +: SET_BITS];
        set_block_offset <= req_addr[5:0];
        set_write_data   <= req_data;
        set_data_size    <= req_size;
        resp_hit         <= 1'b0;
        resp_err         <= 1'b0;
      end
      if (state_q == S_LOOKUP) begin
        resp_hit      <= hit && !misaligned;
        resp_err      <= misaligned;
        set_block_num <= {2'b00, way_sel};
        if (!misaligned && !hit && !inv_any)
          evict_addr <= {set_tags[plru_way], set_idx, 6'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= 4'b0000;
        plru_q[s]  <= 3'b000;
      end
    end else if (state_q == S_WRITE) begin
      valid_q[set_idx][set_block_num[1:0]] <= 1'b1;
      plru_q[set_idx] <= plru_touch(set_plru, set_block_num[1:0]);
    end
  end

  // tags are qualified by valid_q, so they need no reset
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE)
      tag_mem[set_idx][set_block_num[1:0]] <= tag_in;
  end

`ifdef CACHE_STORE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      stat_errs   <= 32'd0;
    end else if ((state_q == S_RESP) && resp_ready) begin
      if (resp_err)      stat_errs   <= stat_errs + 32'd1;
      else if (resp_hit) stat_hits   <= stat_hits + 32'd1;
      else               stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_store_ctrl.sv
// Scoreboard bench for cache_store_ctrl: directed test-plan stores, mid-eviction reset, then random stores.
module tb_cache_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit, resp_err;
  logic        evict_valid;
  logic        evict_ready = 1'b0;
  logic [31:0] evict_addr;
  logic [5:0]  set_sel;
  logic [1:0]  set_enable;
  logic [3:0]  set_block_num;
  logic [5:0]  set_block_offset;
  logic [63:0] set_write_data;
  logic [1:0]  set_data_size;
`ifdef CACHE_STORE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_errs;
`endif

  cache_store_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_err(resp_err),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr),
    .set_sel(set_sel), .set_enable(set_enable), .set_block_num(set_block_num),
    .set_block_offset(set_block_offset), .set_write_data(set_write_data),
    .set_data_size(set_data_size)
`ifdef CACHE_STORE_CTRL_STATS_EN
    ,
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic        hit;
    logic        err;
    logic        evict;
    logic [31:0] evict_addr;
    logic [5:0]  set;
    logic [1:0]  way;
    logic [5:0]  off;
    logic [63:0] data;
    logic [1:0]  size;
    int          write_lat;
    int          resp_lat;
  } exp_t;

  exp_t exp_q[$];

  // reference cache state: per-set way contents and the three tree bits
  bit          m_valid [64][4];
  logic [19:0] m_tag   [64][4];
  bit          m_b0 [64];
  bit          m_b1 [64];
  bit          m_b2 [64];
  int          m_hits = 0, m_misses = 0, m_errs = 0;

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_b0[s] = 1'b0; m_b1[s] = 1'b0; m_b2[s] = 1'b0;
    end
    m_hits = 0; m_misses = 0; m_errs = 0;
  endtask

  task automatic model_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                             input int ew, output exp_t e);
    logic [5:0]  s;
    logic [19:0] t;
    int          off, w;
    s = a[11:6];
    t = a[31:12];
    off = int'(a[5:0]);
    e.set = s; e.off = a[5:0]; e.data = d; e.size = sz;
    e.hit = 1'b0; e.evict = 1'b0; e.evict_addr = '0; e.way = 2'd0;
    e.err = (off % (1 << sz)) != 0;
    if (e.err) begin
      m_errs++;
      e.write_lat = 0;
      e.resp_lat  = 2;
      return;
    end
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w >= 0) begin
      e.hit = 1'b1;
      m_hits++;
    end else begin
      m_misses++;
      for (int i = 0; i < 4; i++)
        if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0) begin
        w = m_b0[s] ? (m_b2[s] ? 3 : 2) : (m_b1[s] ? 1 : 0);
        e.evict = 1'b1;
        e.evict_addr = {m_tag[s][w], s, 6'b0};
      end
    end
    e.way = 2'(w);
    m_valid[s][w] = 1'b1;
    m_tag[s][w] = t;
    if (w < 2) begin m_b0[s] = 1'b1; m_b1[s] = (w == 0); end
    else       begin m_b0[s] = 1'b0; m_b2[s] = (w == 2); end
    e.write_lat = e.evict ? 3 + ew : 2;
    e.resp_lat  = e.write_lat + 1;
  endtask

  // downstream and core responders
  int ev_wait = 0, ev_cnt = 0;
  int r_wait = 0, r_cnt = 0;
  logic idle_hi = 1'b0;
  always @(posedge clk) begin
    #1;
    if (evict_valid) begin evict_ready = (ev_cnt >= ev_wait); ev_cnt++; end
    else begin evict_ready = 1'b0; ev_cnt = 0; end
    if (resp_valid) begin resp_ready = (r_cnt >= r_wait); r_cnt++; end
    else begin resp_ready = idle_hi; r_cnt = 0; end
  end

  // monitor: pops the expectation at accept, checks every output event against it
  exp_t cur;
  bit   have_cur = 0, saw_ev = 0, saw_wr = 0, saw_rv = 0;
  int   acc = 0;
  int   done_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 0;
    end else begin
      if (req_valid && req_ready) begin
        chk("accept_has_expectation", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have_cur = 1; acc = cyc; saw_ev = 0; saw_wr = 0; saw_rv = 0;
        end
      end
      if (set_enable != 2'b00) begin
        chk("set_enable_code", 64'(set_enable), 64'd1);
        chk("write_in_txn", 64'(have_cur && !saw_wr && !cur.err), 64'd1);
        if (have_cur) begin
          chk("write_latency", 64'(cyc - acc), 64'(cur.write_lat));
          chk("set_sel", 64'(set_sel), 64'(cur.set));
          chk("set_block_num", 64'(set_block_num), 64'({2'b00, cur.way}));
          chk("set_block_offset", 64'(set_block_offset), 64'(cur.off));
          chk("set_write_data", set_write_data, cur.data);
          chk("set_data_size", 64'(set_data_size), 64'(cur.size));
          saw_wr = 1;
        end
      end
      if (evict_valid) begin
        chk("evict_expected", 64'(have_cur && cur.evict), 64'd1);
        if (have_cur) begin
          chk("evict_addr", 64'(evict_addr), 64'(cur.evict_addr));
          if (evict_ready) saw_ev = 1;
        end
      end
      if (resp_valid) begin
        chk("resp_in_txn", 64'(have_cur), 64'd1);
        if (have_cur) begin
          if (!saw_rv) chk("resp_latency", 64'(cyc - acc), 64'(cur.resp_lat));
          saw_rv = 1;
          if (resp_ready) begin
            chk("resp_hit", 64'(resp_hit), 64'(cur.hit));
            chk("resp_err", 64'(resp_err), 64'(cur.err));
            chk("evict_seen", 64'(saw_ev), 64'(cur.evict));
            chk("write_seen", 64'(saw_wr), 64'(!cur.err));
            have_cur = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic start_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                             input int ew);
    exp_t e;
    int   n = 0;
    do begin @(posedge clk); #1; n++; end while (!req_ready && n < 200);
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    model_store(a, d, sz, ew, e);
    exp_q.push_back(e);
    ev_wait = ew;
    r_wait  = $urandom_range(0, 2);
    idle_hi = 1'($urandom_range(0, 1));
    req_addr = a; req_data = d; req_size = sz; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_data = {$urandom, $urandom}; req_size = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 300) begin @(negedge clk); n++; end
    chk("resp_done_in_time", 64'(done_cnt != start), 64'd1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                          input int ew);
    start_store(a, d, sz, ew);
    wait_done();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_hit"}, 64'(resp_hit), 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_evict_valid"}, 64'(evict_valid), 64'd0);
    chk({tag, "_evict_addr"}, 64'(evict_addr), 64'd0);
    chk({tag, "_set_enable"}, 64'(set_enable), 64'd0);
    chk({tag, "_set_sel"}, 64'(set_sel), 64'd0);
    chk({tag, "_set_block_num"}, 64'(set_block_num), 64'd0);
    chk({tag, "_set_block_offset"}, 64'(set_block_offset), 64'd0);
    chk({tag, "_set_write_data"}, set_write_data, 64'd0);
    chk({tag, "_set_data_size"}, 64'(set_data_size), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0]  sz;
    logic [5:0]  off;
    logic [31:0] a;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // directed test-plan sequence on set 1
    do_store(32'h0000_1040, 64'h1122334455667788, 2'd3, 0);
    do_store(32'h0000_1045, 64'h0000_0000_0000_00AA, 2'd0, 0);
    do_store(32'h0000_2040, 64'h0101_0101_0101_0101, 2'd3, 0);
    do_store(32'h0000_3040, 64'h0202_0202_0202_0202, 2'd3, 0);
    do_store(32'h0000_4040, 64'h0303_0303_0303_0303, 2'd3, 0);
    do_store(32'h0000_5040, 64'h0404_0404_0404_0404, 2'd3, 3);
    do_store(32'h0000_2043, 64'h0000_0000_DEAD_BEEF, 2'd2, 0);
    do_store(32'h0000_2048, 64'h0505_0505_0505_0505, 2'd3, 0);

    // reset while an eviction is pending
    start_store(32'h0000_6040, 64'h0606_0606_0606_0606, 2'd3, 40);
    n = 0;
    while (!evict_valid && n < 20) begin @(negedge clk); n++; end
    chk("reached_evict", 64'(evict_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    exp_q.delete();
    model_reset();
    ev_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_store(32'h0000_2040, 64'h0707_0707_0707_0707, 2'd3, 0);
    do_store(32'h0000_5040, 64'h0808_0808_0808_0808, 2'd2, 0);

    // random traffic over a few sets and tags to exercise hits, fills, evictions and errors
    for (int k = 0; k < 150; k++) begin
      sz  = 2'($urandom_range(0, 3));
      off = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) off = off & ~6'((1 << sz) - 1);
      a = {20'($urandom_range(1, 6)), 6'($urandom_range(0, 3)), off};
      do_store(a, {$urandom, $urandom}, sz, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("no_txn_pending", 64'(have_cur), 64'd0);
`ifdef CACHE_STORE_CTRL_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'(m_hits));
    chk("stat_misses", 64'(stat_misses), 64'(m_misses));
    chk("stat_errs", 64'(stat_errs), 64'(m_errs));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
